// File: rtl/bandit_pkg.sv
// Shared defaults and the transaction state encoding for the bandit arbiter.
package bandit_pkg;

    localparam int DEFAULT_ACTION_WIDTH = 8;
    localparam int DEFAULT_REWARD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTION = 2'd1,
        REWARD = 2'd2,
        INJECT = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester strictly after the last
// granted index, wrapping modulo NUM_CLIENTS.
module rr_arbiter #(
    parameter int NUM_CLIENTS = 4
) (
    input  logic [NUM_CLIENTS-1:0]         req,
    input  logic [$clog2(NUM_CLIENTS)-1:0] last,
    output logic [$clog2(NUM_CLIENTS)-1:0] pick,
    output logic                           any
);

    localparam int GW = $clog2(NUM_CLIENTS);

    // Distance 0 is the client right after `last`; `last` itself is farthest.
    function automatic int rr_dist(input int idx, input logic [GW-1:0] from);
        return (idx + NUM_CLIENTS - 1 - int'(from)) % NUM_CLIENTS;
    endfunction

    int best;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        best = NUM_CLIENTS;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (req[GW'(i)] && (rr_dist(i, last) < best)) begin
                best = rr_dist(i, last);
                pick = GW'(i);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bandit_arbiter.sv
// Shares one bandit core among several environment clients: one atomic
// action/reward transaction per grant, with a reward timeout fallback.
module bandit_arbiter
    import bandit_pkg::*;
#(
    parameter int                              NUM_CLIENTS    = 4,
    parameter int                              ACTION_WIDTH   = DEFAULT_ACTION_WIDTH,
    parameter int                              REWARD_WIDTH   = DEFAULT_REWARD_WIDTH,
    parameter int                              TIMEOUT        = 1024,
    parameter logic signed [REWARD_WIDTH-1:0]  TIMEOUT_REWARD = '0
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_CLIENTS-1:0]                client_req,
    output logic [NUM_CLIENTS-1:0]                client_action_valid,
    output logic [ACTION_WIDTH-1:0]               client_action_data,
    input  logic [NUM_CLIENTS-1:0]                client_action_ready,
    input  logic [NUM_CLIENTS-1:0]                client_reward_valid,
    input  logic [NUM_CLIENTS*REWARD_WIDTH-1:0]   client_reward_data,
    output logic [NUM_CLIENTS-1:0]                client_reward_ready,
    input  logic                                  core_action_valid,
    input  logic [ACTION_WIDTH-1:0]               core_action_data,
    output logic                                  core_action_ready,
    output logic                                  core_reward_valid,
    output logic [REWARD_WIDTH-1:0]               core_reward_data,
    input  logic                                  core_reward_ready,
    output logic [$clog2(NUM_CLIENTS)-1:0]        grant,
    output logic                                  busy,
    output logic                                  timeout
);

    localparam int GW = $clog2(NUM_CLIENTS);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t          state;
    logic [GW-1:0]   last;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   pick;
    logic            any;
    logic            action_hs;
    logic            reward_hs;

    logic [REWARD_WIDTH-1:0] reward_slice [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_slice
        assign reward_slice[i] = client_reward_data[i*REWARD_WIDTH +: REWARD_WIDTH];
    end

    rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS)) u_rr (
        .req  (client_req),
        .last (last),
        .pick (pick),
        .any  (any)
    );

    assign action_hs = core_action_valid && client_action_ready[grant];
    assign reward_hs = client_reward_valid[grant] && core_reward_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            last    <= GW'(NUM_CLIENTS - 1);
            timer   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        grant <= pick;
                        last  <= pick;
                        state <= ACTION;
                    end
                end
                ACTION: begin
                    if (action_hs) begin
                        state <= REWARD;
                        timer <= '0;
                    end
                end
                REWARD: begin
                    // A handshake in the expiry cycle takes priority over injection.
                    if (reward_hs) begin
                        state <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        state   <= INJECT;
                        timeout <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                INJECT: begin
                    if (core_reward_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Action data is a shared bus; only the owner's valid qualifies it.
    assign client_action_data = core_action_data;

    always_comb begin
        client_action_valid = '0;
        client_reward_ready = '0;
        core_action_ready   = 1'b0;
        core_reward_valid   = 1'b0;
        core_reward_data    = '0;
        case (state)
            ACTION: begin
                client_action_valid[grant] = core_action_valid;
                core_action_ready          = client_action_ready[grant];
            end
            REWARD: begin
                core_reward_valid          = client_reward_valid[grant];
                core_reward_data           = reward_slice[grant];
                client_reward_ready[grant] = core_reward_ready;
            end
            INJECT: begin
                core_reward_valid = 1'b1;
                core_reward_data  = TIMEOUT_REWARD;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bandit_arbiter.sv
// Randomized scoreboard bench for bandit_arbiter with a round-robin reference model.
module tb_bandit_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int RW = 16;
    localparam int TO = 16;
    localparam logic [RW-1:0] TOR = '0;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    client_req;
    logic [N-1:0]    client_action_valid;
    logic [AW-1:0]   client_action_data;
    logic [N-1:0]    client_action_ready;
    logic [N-1:0]    client_reward_valid;
    logic [N*RW-1:0] client_reward_data;
    logic [N-1:0]    client_reward_ready;
    logic            core_action_valid;
    logic [AW-1:0]   core_action_data;
    logic            core_action_ready;
    logic            core_reward_valid;
    logic [RW-1:0]   core_reward_data;
    logic            core_reward_ready;
    logic [1:0]      grant;
    logic            busy;
    logic            timeout;

    bandit_arbiter #(
        .NUM_CLIENTS(N), .ACTION_WIDTH(AW), .REWARD_WIDTH(RW),
        .TIMEOUT(TO), .TIMEOUT_REWARD(TOR)
    ) dut (
        .clock(clock), .reset(reset), .client_req(client_req),
        .client_action_valid(client_action_valid), .client_action_data(client_action_data),
        .client_action_ready(client_action_ready), .client_reward_valid(client_reward_valid),
        .client_reward_data(client_reward_data), .client_reward_ready(client_reward_ready),
        .core_action_valid(core_action_valid), .core_action_data(core_action_data),
        .core_action_ready(core_action_ready), .core_reward_valid(core_reward_valid),
        .core_reward_data(core_reward_data), .core_reward_ready(core_reward_ready),
        .grant(grant), .busy(busy), .timeout(timeout)
    );

    // Clock / reset
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int model_ptr = N - 1;

    // Expected action: {client, data}; expected reward: {timed_out, real data}
    logic [9:0]  act_q[$];
    logic [16:0] rew_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference: first requester after the previous owner, wrapping.
    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        logic [N-1:0] r;
        for (int k = 1; k <= N; k++) begin
            r = req >> ((ptr + k) % N);
            if (r[0]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Monitor / scoreboard
    logic        saw_timeout = 1'b0;
    logic        busy_check  = 1'b0;
    logic [9:0]  ae;
    logic [16:0] re;

    always @(negedge clock) begin
        if (!reset) begin
            if (busy_check) begin
                check("busy_after_reward", 32'(busy), 32'd0);
                busy_check = 1'b0;
            end
            if (timeout) saw_timeout = 1'b1;
            check("action_valid_owner", 32'(client_action_valid & ~(4'b0001 << grant)), 32'd0);
            check("reward_ready_owner", 32'(client_reward_ready & ~(4'b0001 << grant)), 32'd0);
            if (|(client_action_valid & client_action_ready)) begin
                if (act_q.size() == 0) fail("unexpected_action");
                else begin
                    ae = act_q.pop_front();
                    check("grant", 32'(grant), 32'(ae[9:8]));
                    check("action_valid_onehot", 32'(client_action_valid), 32'(4'b0001 << ae[9:8]));
                    check("action_data", 32'(client_action_data), 32'(ae[7:0]));
                    check("core_action_ready", 32'(core_action_ready), 32'd1);
                end
            end
            if (core_reward_valid) begin
                if (rew_q.size() == 0) fail("unexpected_reward");
                else begin
                    re = rew_q[0];
                    check("reward_data", 32'(core_reward_data), saw_timeout ? 32'(TOR) : 32'(re[15:0]));
                    check("busy_in_reward", 32'(busy), 32'd1);
                    if (core_reward_ready) begin
                        void'(rew_q.pop_front());
                        check("timeout_pulse", 32'(saw_timeout), 32'(re[16]));
                        saw_timeout = 1'b0;
                        busy_check  = 1'b1;
                    end
                end
            end
        end
    end

    // Driver: one full transaction, the bench acting as both core and clients.
    task automatic run_txn(input logic [N-1:0] req, input logic [AW-1:0] act, input logic [RW-1:0] base,
                           input int rdelay, input int ready_at, input bit hold_req, input bit abort);
        int  c, hs;
        bit  to, done;
        c = rr_pick(req, model_ptr);
        model_ptr = c;
        hs = (rdelay > ready_at) ? rdelay : ready_at;
        to = (hs > TO - 1);
        if (to) hs = (ready_at > TO) ? ready_at : TO;
        act_q.push_back({c[1:0], act});
        if (!abort) rew_q.push_back({to, base + 16'(c)});
        client_req          = req;
        core_action_valid   = 1'b1;
        core_action_data    = act;
        client_action_ready = '0;
        for (int i = 0; i < N; i++) client_reward_data[i*RW +: RW] = base + 16'(i);

        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clock);
            if (k == 1) check("busy_after_grant", 32'(busy), 32'd1);
            if (|(client_action_valid & client_action_ready)) done = 1'b1;
            else begin
                @(posedge clock); #1;
                client_action_ready = 4'($urandom_range(0, 15));
                if (!hold_req) client_req = 4'($urandom_range(0, 15));
            end
        end
        if (!done) begin
            fail("action_handshake_budget");
            return;
        end
        @(posedge clock); #1;
        core_action_valid   = 1'b0;
        client_action_ready = '0;

        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (abort && k == 3) begin
                reset = 1'b1;
                client_reward_valid = '0;
                core_reward_ready = 1'b1;
                client_req = '0;
                @(posedge clock); #1;
                reset = 1'b0;
                model_ptr = N - 1;
                @(negedge clock);
                check("reset_mid_busy", 32'(busy), 32'd0);
                check("reset_mid_grant", 32'(grant), 32'd0);
                check("reset_mid_outputs", 32'({client_action_valid, client_reward_ready,
                      core_action_ready, core_reward_valid, timeout}), 32'd0);
                @(posedge clock); #1;
                core_reward_ready = 1'b0;
                return;
            end
            client_reward_valid = (k >= rdelay) ? '1 : '0;
            core_reward_ready   = (k >= ready_at);
            @(negedge clock);
            if (k >= TO) check("late_reward_ignored", 32'(client_reward_ready), 32'd0);
            if (core_reward_valid && core_reward_ready) begin
                done = 1'b1;
                check("reward_latency", 32'(k), 32'(hs));
            end else begin
                @(posedge clock); #1;
            end
        end
        if (!done) begin
            fail("reward_handshake_budget");
            return;
        end
        @(posedge clock); #1;
        client_reward_valid = '0;
        core_reward_ready   = 1'b0;
        if (!hold_req) client_req = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        client_req = '0;
        client_action_ready = '0;
        client_reward_valid = '0;
        client_reward_data = '0;
        core_action_valid = 1'b0;
        core_action_data = '0;
        core_reward_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_outputs", 32'({client_action_valid, client_reward_ready,
              core_action_ready, core_reward_valid, timeout}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // All requesting: grants rotate 0,1,2,3,0,1,2,3
        for (int t = 0; t < 8; t++)
            run_txn(4'b1111, 8'($urandom), 16'($urandom), $urandom_range(0, 5), 0, 1'b1, 1'b0);
        // Single requester, fixed values
        run_txn(4'b0001, 8'h2A, 16'd100, 0, 0, 1'b0, 1'b0);
        // Silent client 2: timeout injects default reward
        run_txn(4'b0100, 8'h11, 16'hBEEF, 20, 0, 1'b0, 1'b0);
        // Reward arrives in the expiry cycle
        run_txn(4'b0010, 8'h22, 16'hFF9C, TO - 1, 0, 1'b0, 1'b0);
        // Core stalls reward in REWARD, then in INJECT
        run_txn(4'b1000, 8'h33, 16'h0123, 2, 7, 1'b0, 1'b0);
        run_txn(4'b0001, 8'h44, 16'h8000, 20, TO + 5, 1'b0, 1'b0);
        // Reset in REWARD, then pointer restarts at client 0
        run_txn(4'b0100, 8'h55, 16'h7777, 30, 0, 1'b0, 1'b1);
        run_txn(4'b1111, 8'h66, 16'h0042, 1, 0, 1'b0, 1'b0);
        // Random traffic
        for (int t = 0; t < 40; t++)
            run_txn(4'($urandom_range(1, 15)), 8'($urandom), 16'($urandom),
                    $urandom_range(0, 18), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0,
                    1'($urandom_range(0, 1)), 1'b0);

        repeat (4) @(posedge clock);
        check("action_queue_drained", 32'(act_q.size()), 32'd0);
        check("reward_queue_drained", 32'(rew_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
